// File: rtl/ospi_host_ctrl.sv
// Octal-SPI host: one transaction per start pulse (opcode, address, dummy, data),
// SDR, one byte per OSPI_CLK cycle, all pad-facing outputs registered.
module ospi_host_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_BYTES = 3,
    parameter int CLK_DIV    = 1,
    parameter int DUMMY_W    = 4,
    parameter int LEN_W      = 8,
    parameter int CSH        = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    rw,
    input  logic [7:0]              cmd,
    input  logic [8*ADDR_BYTES-1:0] addr,
    input  logic                    addr_en,
    input  logic [DUMMY_W-1:0]      dummy,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    output logic                    done,
    input  logic [WIDTH-1:0]        tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [WIDTH-1:0]        rx_data,
    output logic                    rx_valid,
    output logic                    OSPI_CLK,
    output logic                    OSPI_CS,
    output logic [WIDTH-1:0]        OSPI_IO_OUT,
    output logic                    OSPI_IO_OE,
    input  logic [WIDTH-1:0]        OSPI_IO_IN,
    output logic [2:0]              dbg_state
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int A_W   = $clog2(ADDR_BYTES + 1);
    localparam int H_W   = $clog2(CSH + 1);
    localparam int M1    = (LEN_W > DUMMY_W) ? LEN_W : DUMMY_W;
    localparam int M2    = (A_W > H_W) ? A_W : H_W;
    localparam int CNT_W = (M1 > M2) ? M1 : M2;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD, S_CSHI
    } state_t;

    state_t                  state_q, state_n, seq_state;
    logic                    half_q, half_n;
    logic                    stall_q, stall_n;
    logic [DIV_W-1:0]        div_q, div_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n, seq_cnt;
    logic                    rw_q, rw_n, addr_en_q, addr_en_n;
    logic [8*ADDR_BYTES-1:0] addr_q, addr_n;
    logic [DUMMY_W-1:0]      dummy_q, dummy_n;
    logic [LEN_W-1:0]        len_q, len_n;
    logic                    clk_q, clk_n, cs_q, cs_n, oe_q, oe_n;
    logic [WIDTH-1:0]        out_q, out_n, rx_data_q, rx_data_n;
    logic                    done_q, done_n, rx_valid_q, rx_valid_n;
    logic [7:0]              addr_byte;
    logic                    phase_end, in_byte, byte_end;

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign OSPI_CLK    = clk_q;
    assign OSPI_CS     = cs_q;
    assign OSPI_IO_OUT = out_q;
    assign OSPI_IO_OE  = oe_q;
    assign dbg_state   = state_q;

    // Write bytes use valid/ready: a byte moves on a clk edge where tx_valid and
    // tx_ready are both high; tx_ready never depends on tx_valid, and once raised
    // it stays high (OSPI_CLK parked low) until the byte is taken.
    always_comb begin
        state_n    = state_q;
        half_n     = half_q;
        stall_n    = stall_q;
        div_n      = div_q;
        cnt_n      = cnt_q;
        rw_n       = rw_q;
        addr_en_n  = addr_en_q;
        addr_n     = addr_q;
        dummy_n    = dummy_q;
        len_n      = len_q;
        clk_n      = clk_q;
        cs_n       = cs_q;
        oe_n       = oe_q;
        out_n      = out_q;
        rx_data_n  = rx_data_q;
        done_n     = 1'b0;
        rx_valid_n = 1'b0;

        // Byte that follows the current one, skipping empty phases.
        seq_state = S_HOLD;
        seq_cnt   = '0;
        if (state_q == S_CMD && addr_en_q) begin
            seq_state = S_ADDR;
            seq_cnt   = CNT_W'(ADDR_BYTES);
        end else if (state_q == S_ADDR && cnt_q > CNT_W'(1)) begin
            seq_state = S_ADDR;
            seq_cnt   = cnt_q - CNT_W'(1);
        end else if ((state_q == S_CMD || state_q == S_ADDR) && dummy_q != '0) begin
            seq_state = S_DUMMY;
            seq_cnt   = CNT_W'(dummy_q);
        end else if (state_q == S_DUMMY && cnt_q > CNT_W'(1)) begin
            seq_state = S_DUMMY;
            seq_cnt   = cnt_q - CNT_W'(1);
        end else if ((state_q == S_CMD || state_q == S_ADDR || state_q == S_DUMMY)
                     && len_q != '0) begin
            seq_state = S_DATA;
            seq_cnt   = CNT_W'(len_q);
        end else if (state_q == S_DATA && cnt_q > CNT_W'(1)) begin
            seq_state = S_DATA;
            seq_cnt   = cnt_q - CNT_W'(1);
        end

        // Remaining-byte count selects the address byte, so MSB goes first.
        addr_byte = '0;
        for (int i = 0; i < ADDR_BYTES; i++) begin
            if (CNT_W'(i + 1) == seq_cnt) addr_byte = addr_q[8*i +: 8];
        end

        phase_end = (div_q == DIV_W'(CLK_DIV - 1));
        in_byte   = (state_q == S_CMD) || (state_q == S_ADDR) ||
                    (state_q == S_DUMMY) || (state_q == S_DATA);
        byte_end  = in_byte && !stall_q && half_q && phase_end;
        tx_ready  = stall_q || (byte_end && seq_state == S_DATA && !rw_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_CMD;
                    half_n    = 1'b0;
                    stall_n   = 1'b0;
                    div_n     = '0;
                    rw_n      = rw;
                    addr_en_n = addr_en;
                    addr_n    = addr;
                    dummy_n   = dummy;
                    len_n     = len;
                    cs_n      = 1'b0;
                    clk_n     = 1'b0;
                    oe_n      = 1'b1;
                    out_n     = WIDTH'(cmd);
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (stall_q) begin
                    if (tx_valid) begin
                        stall_n = 1'b0;
                        div_n   = '0;
                        half_n  = 1'b0;
                        oe_n    = 1'b1;
                        out_n   = tx_data;
                    end
                end else if (!phase_end) begin
                    div_n = div_q + DIV_W'(1);
                end else if (!half_q) begin
                    half_n = 1'b1;
                    clk_n  = 1'b1;
                    div_n  = '0;
                    if (state_q == S_DATA && rw_q) begin
                        rx_data_n  = OSPI_IO_IN;
                        rx_valid_n = 1'b1;
                    end
                end else begin
                    half_n  = 1'b0;
                    clk_n   = 1'b0;
                    div_n   = '0;
                    state_n = seq_state;
                    cnt_n   = seq_cnt;
                    case (seq_state)
                        S_ADDR: begin
                            oe_n  = 1'b1;
                            out_n = WIDTH'(addr_byte);
                        end
                        S_DATA: begin
                            if (rw_q) begin
                                oe_n  = 1'b0;
                                out_n = '0;
                            end else if (tx_valid) begin
                                oe_n  = 1'b1;
                                out_n = tx_data;
                            end else begin
                                stall_n = 1'b1;
                            end
                        end
                        default: begin
                            oe_n  = 1'b0;
                            out_n = '0;
                        end
                    endcase
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    state_n = S_CSHI;
                    cs_n    = 1'b1;
                    cnt_n   = CNT_W'(CSH);
                    div_n   = '0;
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            S_CSHI: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            half_q     <= 1'b0;
            stall_q    <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            addr_en_q  <= 1'b0;
            addr_q     <= '0;
            dummy_q    <= '0;
            len_q      <= '0;
            clk_q      <= 1'b0;
            cs_q       <= 1'b1;
            oe_q       <= 1'b0;
            out_q      <= '0;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            half_q     <= half_n;
            stall_q    <= stall_n;
            div_q      <= div_n;
            cnt_q      <= cnt_n;
            rw_q       <= rw_n;
            addr_en_q  <= addr_en_n;
            addr_q     <= addr_n;
            dummy_q    <= dummy_n;
            len_q      <= len_n;
            clk_q      <= clk_n;
            cs_q       <= cs_n;
            oe_q       <= oe_n;
            out_q      <= out_n;
            rx_data_q  <= rx_data_n;
            done_q     <= done_n;
            rx_valid_q <= rx_valid_n;
        end
    end

endmodule

// File: tb/tb_ospi_host_ctrl.sv
// Bench for ospi_host_ctrl: two instances (CLK_DIV=1 and CLK_DIV=3) driven by a
// vector table, hand sequences and random transactions checked against a lane model.
module tb_ospi_host_ctrl;

    localparam int AB  = 3;
    localparam int CSH = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start [2];
    logic       rw [2];
    logic [7:0] cmd [2];
    logic [23:0] addr [2];
    logic       addr_en [2];
    logic [3:0] dummy [2];
    logic [7:0] len [2];
    logic       busy [2];
    logic       done [2];
    logic [7:0] tx_data [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic [7:0] rx_data [2];
    logic       rx_valid [2];
    logic       ospi_clk [2];
    logic       ospi_cs [2];
    logic [7:0] io_out [2];
    logic       io_oe [2];
    logic [7:0] io_in [2];
    logic [2:0] dbg_state [2];

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_rx_q[$];

    // clock / reset
    always #5 clk = ~clk;

    ospi_host_ctrl #(.CLK_DIV(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .rw(rw[0]), .cmd(cmd[0]),
        .addr(addr[0]), .addr_en(addr_en[0]), .dummy(dummy[0]), .len(len[0]),
        .busy(busy[0]), .done(done[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .OSPI_CLK(ospi_clk[0]), .OSPI_CS(ospi_cs[0]), .OSPI_IO_OUT(io_out[0]),
        .OSPI_IO_OE(io_oe[0]), .OSPI_IO_IN(io_in[0]), .dbg_state(dbg_state[0]));

    ospi_host_ctrl #(.CLK_DIV(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .rw(rw[1]), .cmd(cmd[1]),
        .addr(addr[1]), .addr_en(addr_en[1]), .dummy(dummy[1]), .len(len[1]),
        .busy(busy[1]), .done(done[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .OSPI_CLK(ospi_clk[1]), .OSPI_CS(ospi_cs[1]), .OSPI_IO_OUT(io_out[1]),
        .OSPI_IO_OE(io_oe[1]), .OSPI_IO_IN(io_in[1]), .dbg_state(dbg_state[1]));

    typedef struct {
        int          u;
        logic        rw;
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic        aen;
        logic [3:0]  dum;
        logic [7:0]  len;
        logic [31:0] d;
        int          stall_at;
        int          stall_n;
        int          restart_t;
        int          exp_done;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_idle(input int u, input string tag);
        check($sformatf("%s_cs", tag), 32'(ospi_cs[u]), 32'd1);
        check($sformatf("%s_clk", tag), 32'(ospi_clk[u]), 32'd0);
        check($sformatf("%s_oe", tag), 32'(io_oe[u]), 32'd0);
        check($sformatf("%s_out", tag), 32'(io_out[u]), 32'd0);
        check($sformatf("%s_busy", tag), 32'(busy[u]), 32'd0);
        check($sformatf("%s_done", tag), 32'(done[u]), 32'd0);
        check($sformatf("%s_txrdy", tag), 32'(tx_ready[u]), 32'd0);
        check($sformatf("%s_rxv", tag), 32'(rx_valid[u]), 32'd0);
        check($sformatf("%s_rxd", tag), 32'(rx_data[u]), 32'd0);
    endtask

    // driver + monitor for one transaction; src_q holds the write or flash bytes
    task automatic run_txn(input int u, input logic rw_i, input logic [7:0] cmd_i,
                           input logic [23:0] addr_i, input logic aen_i,
                           input logic [3:0] dum_i, input logic [7:0] len_i,
                           input int stall_at, input int stall_n,
                           input int restart_t, input int exp_done_tab);
        int div, nb, exp_done, limit, pre;
        int t_done, n_done, n_acc, stall_left, rises, hi_run, lo_run, perr;
        logic p_clk, p_cs, p_stall, vld;
        logic [7:0] p_out;
        logic [7:0] got_q[$];
        logic [7:0] got_rx_q[$];

        div = (u == 0) ? 1 : 3;
        nb  = 1 + (aen_i ? AB : 0) + int'(dum_i) + int'(len_i);
        exp_done = 2 * div * nb + div + CSH;
        if (!rw_i && stall_n > 0 && stall_at < int'(len_i)) exp_done += stall_n;
        if (exp_done_tab >= 0) exp_done = exp_done_tab;

        exp_q.delete();
        exp_rx_q.delete();
        exp_q.push_back(cmd_i);
        if (aen_i) for (int i = AB - 1; i >= 0; i--) exp_q.push_back(addr_i[8*i +: 8]);
        for (int i = 0; i < int'(len_i); i++) begin
            if (rw_i) exp_rx_q.push_back(src_q[i]);
            else exp_q.push_back(src_q[i]);
        end

        @(negedge clk);
        start[u] = 1'b1; rw[u] = rw_i; cmd[u] = cmd_i; addr[u] = addr_i;
        addr_en[u] = aen_i; dummy[u] = dum_i; len[u] = len_i;
        @(posedge clk);

        pre = 1 + (aen_i ? AB : 0) + int'(dum_i);
        p_clk = 1'b0; p_cs = 1'b1; p_stall = 1'b0; p_out = '0;
        t_done = -1; n_done = 0; n_acc = 0; stall_left = stall_n;
        rises = 0; hi_run = 0; lo_run = 0; perr = 0;
        limit = exp_done + 6;
        for (int t = 0; t <= limit; t++) begin
            @(negedge clk);
            if (ospi_cs[u] && ospi_clk[u]) perr++;
            if (ospi_cs[u] && !p_cs && p_clk) perr++;
            if (p_stall && (io_out[u] !== p_out || ospi_clk[u])) perr++;
            if (ospi_clk[u] && !p_clk) begin
                if (io_oe[u]) got_q.push_back(io_out[u]);
                if (lo_run < div) perr++;
                rises++;
                lo_run = 0;
            end
            if (!ospi_clk[u] && p_clk) begin
                if (hi_run != div) perr++;
                hi_run = 0;
            end
            if (ospi_clk[u]) hi_run++;
            else if (!ospi_cs[u]) lo_run++;
            if (rx_valid[u]) got_rx_q.push_back(rx_data[u]);
            if (done[u]) begin
                n_done++;
                if (t_done < 0) t_done = t;
                if (busy[u]) perr++;
            end
            if (t < exp_done && !busy[u]) perr++;

            if (t == 0) begin
                start[u] = 1'b0;
                rw[u] = 1'($urandom); cmd[u] = 8'($urandom); addr[u] = 24'($urandom);
                addr_en[u] = 1'($urandom); dummy[u] = 4'($urandom); len[u] = 8'($urandom);
            end
            if (t == restart_t) start[u] = 1'b1;
            if (t == restart_t + 1) start[u] = 1'b0;

            vld = !(!rw_i && n_acc == stall_at && stall_left > 0);
            tx_valid[u] = vld;
            tx_data[u]  = (n_acc < int'(len_i)) ? src_q[n_acc] : 8'($urandom);
            p_stall = tx_ready[u] && !vld;
            if (p_stall) stall_left--;
            if (tx_ready[u] && vld) n_acc++;
            io_in[u] = 8'($urandom);
            if (rw_i && !ospi_clk[u] && rises >= pre && rises - pre < int'(len_i))
                io_in[u] = src_q[rises - pre];
            p_clk = ospi_clk[u];
            p_cs  = ospi_cs[u];
            p_out = io_out[u];
        end
        tx_valid[u] = 1'b0;

        // scoreboard
        check("lane_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("lane%0d", i), got_q[i], exp_q[i]);
        check("rx_count", got_rx_q.size(), exp_rx_q.size());
        for (int i = 0; i < exp_rx_q.size() && i < got_rx_q.size(); i++)
            check($sformatf("rx%0d", i), got_rx_q[i], exp_rx_q[i]);
        check("done_time", t_done, exp_done);
        check("done_count", n_done, 1);
        check("tx_accepts", n_acc, rw_i ? 0 : int'(len_i));
        check("protocol", perr, 0);
    endtask

    initial begin
        int u, lr;
        logic [3:0] dr;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; rw[i] = 1'b0; cmd[i] = '0; addr[i] = '0; addr_en[i] = 1'b0;
            dummy[i] = '0; len[i] = '0; tx_data[i] = '0; tx_valid[i] = 1'b0; io_in[i] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle(0, "post0");

        // reset in the middle of a write data phase
        start[0] = 1'b1; rw[0] = 1'b0; cmd[0] = 8'h02; addr_en[0] = 1'b0;
        dummy[0] = '0; len[0] = 8'd10; tx_valid[0] = 1'b1; tx_data[0] = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", 32'(busy[0]), 32'd1);
        check("mid_oe", 32'(io_oe[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check_idle(0, "mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        tx_valid[0] = 1'b0;

        vt[0] = '{0, 1'b0, 8'h06, 24'h000000, 1'b0, 4'd0, 8'd0, 32'h0, 0, 0, -1, 5};
        vt[1] = '{0, 1'b0, 8'h02, 24'h123456, 1'b1, 4'd0, 8'd2, 32'hA55A0000, 0, 0, -1, 15};
        vt[2] = '{0, 1'b0, 8'h02, 24'h123456, 1'b1, 4'd0, 8'd2, 32'hA55A0000, 1, 4, -1, 19};
        vt[3] = '{0, 1'b1, 8'h0B, 24'h000010, 1'b1, 4'd4, 8'd3, 32'h11223300, 0, 0, -1, 25};
        vt[4] = '{1, 1'b0, 8'h02, 24'h000000, 1'b0, 4'd0, 8'd1, 32'hC3000000, 0, 0, 3, 17};
        vt[5] = '{1, 1'b1, 8'h9F, 24'h000000, 1'b0, 4'd2, 8'd2, 32'hDEAD0000, 0, 0, -1, 35};
        vt[6] = '{0, 1'b0, 8'h20, 24'hABCDEF, 1'b1, 4'd0, 8'd0, 32'h0, 0, 0, -1, 11};
        vt[7] = '{0, 1'b0, 8'h32, 24'h000000, 1'b0, 4'd1, 8'd1, 32'h77000000, 0, 2, -1, 11};
        for (int k = 0; k < 8; k++) begin
            src_q.delete();
            for (int i = 0; i < 4; i++) src_q.push_back(vt[k].d[31-8*i -: 8]);
            run_txn(vt[k].u, vt[k].rw, vt[k].cmd, vt[k].addr, vt[k].aen, vt[k].dum,
                    vt[k].len, vt[k].stall_at, vt[k].stall_n, vt[k].restart_t,
                    vt[k].exp_done);
        end

        // random transactions, including maximum len and dummy
        for (int k = 0; k < 24; k++) begin
            u  = (k % 3 == 2) ? 1 : 0;
            lr = (k == 0) ? 255 : int'($urandom_range(0, 6));
            dr = (k == 1) ? 4'd15 : 4'($urandom_range(0, 15));
            src_q.delete();
            for (int i = 0; i < lr; i++) src_q.push_back(8'($urandom));
            run_txn(u, 1'($urandom), 8'($urandom), 24'($urandom), 1'($urandom), dr,
                    8'(lr), int'($urandom_range(0, lr)), int'($urandom_range(0, 5)),
                    int'($urandom_range(1, 3)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
